// File: rtl/pwm_monitor_pkg.sv
// Shared types and default parameters for the PWM period/high-time monitor.
package pwm_monitor_pkg;

    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned TIMEOUT_CYC_DEF = 1000000;
    localparam int unsigned TRIG_W_DEF      = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RISE,
        ST_MEAS_HIGH,
        ST_MEAS_LOW
    } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus registered rise/fall pulses for one async input.
// Edge detection is held off until the previous-sample flop holds a real
// synchronized value, so an input already high at reset release gives no rise.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic prev;
    logic v1;
    logic v2;
    logic armed;

    // Synchronize, track the previous sample and emit one-cycle edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            prev  <= 1'b0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            armed <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            prev  <= s2;
            v1    <= 1'b1;
            v2    <= v1;
            armed <= v2;
            rise  <= armed & s2 & ~prev;
            fall  <= armed & ~s2 & prev;
        end
    end

endmodule

// File: rtl/pwm_monitor.sv
// Measures period and high time of a PWM input, counts trigger pulses and
// raises a sticky interrupt on completed measurements or timeouts.
module pwm_monitor
    import pwm_monitor_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned TRIG_W      = TRIG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              pwm_i,
    input  logic              trigger_i,
    input  logic              clear_i,
    input  logic              irq_en_i,
    output logic [CNT_W-1:0]  period_o,
    output logic [CNT_W-1:0]  high_o,
    output logic              meas_valid_o,
    output logic              timeout_o,
    output logic [TRIG_W-1:0] trig_count_o,
    output logic              irq_o,
    output logic              busy_o
);

    localparam int unsigned      TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] high_lat;
    logic [TO_W-1:0]  tcnt;
    logic             to_hit;
    logic             pwm_rise;
    logic             pwm_fall;
    logic             trig_rise;
    logic             trig_fall_unused;

    sync_edge_det u_pwm_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (pwm_i),
        .rise (pwm_rise),
        .fall (pwm_fall)
    );

    sync_edge_det u_trig_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (trigger_i),
        .rise (trig_rise),
        .fall (trig_fall_unused)
    );

    // Saturating increment and timeout compare.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign to_hit  = (tcnt == TO_LAST);

    // Measurement FSM; tcnt counts cycles since the last accepted edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            high_lat     <= '0;
            tcnt         <= '0;
            period_o     <= '0;
            high_o       <= '0;
            meas_valid_o <= 1'b0;
            timeout_o    <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            meas_valid_o <= 1'b0;
            timeout_o    <= 1'b0;
            if (!enable_i) begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
                cnt    <= '0;
                tcnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state  <= ST_WAIT_RISE;
                        busy_o <= 1'b1;
                        cnt    <= '0;
                        tcnt   <= '0;
                    end
                    ST_WAIT_RISE: begin
                        if (pwm_rise) begin
                            state <= ST_MEAS_HIGH;
                            cnt   <= CNT_W'(1);
                            tcnt  <= '0;
                        end else if (to_hit) begin
                            timeout_o <= 1'b1;
                            tcnt      <= '0;
                        end else begin
                            tcnt <= tcnt + TO_W'(1);
                        end
                    end
                    ST_MEAS_HIGH: begin
                        if (pwm_fall) begin
                            state    <= ST_MEAS_LOW;
                            high_lat <= cnt;
                            cnt      <= cnt_inc;
                            tcnt     <= '0;
                        end else if (to_hit) begin
                            state     <= ST_WAIT_RISE;
                            timeout_o <= 1'b1;
                            cnt       <= '0;
                            tcnt      <= '0;
                        end else begin
                            cnt  <= cnt_inc;
                            tcnt <= tcnt + TO_W'(1);
                        end
                    end
                    ST_MEAS_LOW: begin
                        if (pwm_rise) begin
                            state        <= ST_MEAS_HIGH;
                            period_o     <= cnt;
                            high_o       <= high_lat;
                            meas_valid_o <= 1'b1;
                            cnt          <= CNT_W'(1);
                            tcnt         <= '0;
                        end else if (to_hit) begin
                            state     <= ST_WAIT_RISE;
                            timeout_o <= 1'b1;
                            cnt       <= '0;
                            tcnt      <= '0;
                        end else begin
                            cnt  <= cnt_inc;
                            tcnt <= tcnt + TO_W'(1);
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Trigger edge counter; a clear coinciding with an edge leaves a count of one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_count_o <= '0;
        end else if (clear_i) begin
            trig_count_o <= trig_rise ? TRIG_W'(1) : '0;
        end else if (trig_rise) begin
            trig_count_o <= trig_count_o + TRIG_W'(1);
        end
    end

    // Sticky interrupt; setting takes priority over clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_o <= 1'b0;
        end else if ((meas_valid_o | timeout_o) & irq_en_i) begin
            irq_o <= 1'b1;
        end else if (clear_i) begin
            irq_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_monitor.sv
// Directed and randomized checks of pwm_monitor against a waveform-level model:
// every driven rise that closes a full period queues the expected period/high.
module tb_pwm_monitor;

    localparam int unsigned CNT_W       = 32;
    localparam int unsigned TIMEOUT_CYC = 500;
    localparam int unsigned TRIG_W      = 16;

    logic              clk;
    logic              rst;
    logic              enable_i;
    logic              pwm_i;
    logic              trigger_i;
    logic              clear_i;
    logic              irq_en_i;
    logic [CNT_W-1:0]  period_o;
    logic [CNT_W-1:0]  high_o;
    logic              meas_valid_o;
    logic              timeout_o;
    logic [TRIG_W-1:0] trig_count_o;
    logic              irq_o;
    logic              busy_o;

    pwm_monitor #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TRIG_W      (TRIG_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .pwm_i        (pwm_i),
        .trigger_i    (trigger_i),
        .clear_i      (clear_i),
        .irq_en_i     (irq_en_i),
        .period_o     (period_o),
        .high_o       (high_o),
        .meas_valid_o (meas_valid_o),
        .timeout_o    (timeout_o),
        .trig_count_o (trig_count_o),
        .irq_o        (irq_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int p;
        int h;
    } meas_t;

    int    checks;
    int    failures;
    int    cyc;
    int    last_rise;
    int    last_fall;
    int    n_valid;
    int    exp_valid;
    int    last_p;
    int    last_h;
    int    exp_trig;
    meas_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample after the edge and score any measurement pulse.
    task automatic tick();
        meas_t m;
        @(posedge clk);
        #1;
        cyc++;
        if (meas_valid_o === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("spurious_meas_valid", 64'(meas_valid_o), 64'd0);
            end else begin
                m = exp_q.pop_front();
                check("period", 64'(period_o), 64'(m.p));
                check("high", 64'(high_o), 64'(m.h));
                last_p = m.p;
                last_h = m.h;
            end
        end
    endtask

    // One PWM cycle of h high then l low; a rise after a complete period queues a result.
    task automatic pulse(input int h, input int l);
        if (last_rise >= 0) begin
            exp_q.push_back('{cyc - last_rise, last_fall - last_rise});
            exp_valid++;
        end
        last_rise = cyc;
        pwm_i = 1'b1;
        repeat (h) tick();
        last_fall = cyc;
        pwm_i = 1'b0;
        repeat (l) tick();
    endtask

    initial begin
        int n;
        int nv0;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        last_rise = -1;
        last_fall = -1;
        n_valid   = 0;
        exp_valid = 0;
        last_p    = 0;
        last_h    = 0;
        exp_trig  = 0;
        rst       = 1'b1;
        enable_i  = 1'b0;
        pwm_i     = 1'b0;
        trigger_i = 1'b0;
        clear_i   = 1'b0;
        irq_en_i  = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_period", 64'(period_o), 64'd0);
        check("rst_high", 64'(high_o), 64'd0);
        check("rst_trig", 64'(trig_count_o), 64'd0);
        check("rst_irq", 64'(irq_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_timeout", 64'(timeout_o), 64'd0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_busy", 64'(busy_o), 64'd0);

        // Ten triggers of random width, then clear coinciding with the 11th edge
        for (int i = 0; i < 10; i++) begin
            trigger_i = 1'b1;
            repeat ($urandom_range(3, 1)) tick();
            trigger_i = 1'b0;
            repeat ($urandom_range(3, 1)) tick();
            exp_trig++;
        end
        repeat (4) tick();
        check("trig_count_10", 64'(trig_count_o), 64'(exp_trig));
        trigger_i = 1'b1;
        repeat (3) tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("trig_clear_with_edge", 64'(trig_count_o), 64'd1);
        trigger_i = 1'b0;
        repeat (4) tick();

        // 25/75 PWM: results from the second rising edge onward
        enable_i  = 1'b1;
        last_rise = -1;
        repeat (5) tick();
        check("busy_enabled", 64'(busy_o), 64'd1);
        for (int i = 0; i < 4; i++) pulse(25, 75);
        check("p25_period", 64'(period_o), 64'd100);
        check("p25_high", 64'(high_o), 64'd25);
        check("p25_count", 64'(n_valid), 64'(exp_valid));

        // Drop enable in the low phase: busy falls next cycle, partial period discarded
        pulse(25, 0);
        repeat (30) tick();
        check("busy_mid_low", 64'(busy_o), 64'd1);
        enable_i = 1'b0;
        tick();
        check("busy_after_disable", 64'(busy_o), 64'd0);
        repeat (20) tick();
        enable_i  = 1'b1;
        last_rise = -1;
        repeat (5) tick();
        for (int i = 0; i < 3; i++) pulse(40, 60);
        check("p40_period", 64'(period_o), 64'd100);
        check("p40_high", 64'(high_o), 64'd40);

        // Minimum widths: 1 high / 2 low
        for (int i = 0; i < 5; i++) pulse(1, 2);
        repeat (6) tick();
        check("p1_period", 64'(period_o), 64'd3);
        check("p1_high", 64'(high_o), 64'd1);

        // Randomized waveform with interrupts masked
        irq_en_i = 1'b0;
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int i = 0; i < 20; i++) pulse(int'($urandom_range(60, 1)), int'($urandom_range(60, 1)));
        repeat (6) tick();
        check("irq_masked", 64'(irq_o), 64'd0);
        check("rand_count", 64'(n_valid), 64'(exp_valid));

        // PWM already high at reset release: no result before a full low-high-low-high
        pwm_i = 1'b1;
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("rst2_period", 64'(period_o), 64'd0);
        last_p    = 0;
        last_h    = 0;
        last_rise = -1;
        nv0       = n_valid;
        repeat (20) tick();
        pwm_i = 1'b0;
        repeat (30) tick();
        check("no_spurious_after_rst", 64'(n_valid), 64'(nv0));
        for (int i = 0; i < 3; i++) pulse(10, 20);
        check("p10_period", 64'(period_o), 64'd30);
        check("p10_high", 64'(high_o), 64'd10);

        // Timeout with PWM held low
        enable_i = 1'b0;
        repeat (3) tick();
        clear_i = 1'b1;
        tick();
        clear_i  = 1'b0;
        irq_en_i = 1'b1;
        enable_i = 1'b1;
        n = 0;
        while (busy_o !== 1'b1 && n < 5) begin
            tick();
            n++;
        end
        check("busy_rise", 64'(busy_o), 64'd1);
        n = 0;
        while (timeout_o !== 1'b1 && n < 700) begin
            tick();
            n++;
        end
        check("timeout_latency", 64'(n), 64'(TIMEOUT_CYC));
        check("timeout_period_kept", 64'(period_o), 64'(last_p));
        check("timeout_high_kept", 64'(high_o), 64'(last_h));
        tick();
        check("timeout_pulse_width", 64'(timeout_o), 64'd0);
        check("irq_on_timeout", 64'(irq_o), 64'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("irq_cleared", 64'(irq_o), 64'd0);

        check("pending_results", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_monitor.md
PWM_MONITOR -- requirements
Module: pwm_monitor

Interface
REQ-001 Parameter CNT_W, default 32, width of period/high-time counters and results.
REQ-002 Parameter TIMEOUT_CYC, default 1000000, maximum cycles without an expected edge before a measurement is abandoned.
REQ-003 Parameter TRIG_W, default 16, width of trigger event counter.
REQ-004 clk  input  1  single block clock, all state on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 enable_i  input  1  measurement enable; low forces IDLE.
REQ-007 pwm_i  input  1  asynchronous PWM waveform (timer pwm_o).
REQ-008 trigger_i  input  1  asynchronous trigger pulse (timer trigger_o).
REQ-009 clear_i  input  1  synchronous clear of irq_o and trig_count_o.
REQ-010 irq_en_i  input  1  allows meas_valid_o/timeout_o to set irq_o.
REQ-011 period_o  output  CNT_W  last complete period in clk cycles.
REQ-012 high_o  output  CNT_W  last complete high time in clk cycles.
REQ-013 meas_valid_o  output  1  one-cycle pulse when period_o/high_o update.
REQ-014 timeout_o  output  1  one-cycle pulse on timeout abandonment.
REQ-015 trig_count_o  output  TRIG_W  count of trigger_i rising edges.
REQ-016 irq_o  output  1  sticky interrupt.
REQ-017 busy_o  output  1  high in any state other than IDLE.

Function
REQ-018 pwm_i and trigger_i SHALL each pass through a two-flop synchronizer followed by an edge-detect register; edges are seen 3 cycles after the input changes.
REQ-019 FSM states SHALL be IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
REQ-020 IDLE -> WAIT_RISE when enable_i=1; any state -> IDLE within 1 cycle when enable_i=0, discarding partial counts.
REQ-021 WAIT_RISE: on synchronized rising edge -> MEAS_HIGH, counter loaded with 1.
REQ-022 MEAS_HIGH: counter increments each cycle; on falling edge latch counter into internal high register -> MEAS_LOW, counter keeps incrementing.
REQ-023 MEAS_LOW: on rising edge, period_o <= counter, high_o <= latched high, meas_valid_o=1 next cycle, counter reloaded with 1, -> MEAS_HIGH (back-to-back measurements, no lost period).
REQ-024 Counter SHALL saturate at 2^CNT_W-1, never wrap.
REQ-025 In WAIT_RISE, MEAS_HIGH or MEAS_LOW, if cycles since last accepted edge reach TIMEOUT_CYC -> pulse timeout_o, -> WAIT_RISE; period_o/high_o unchanged.
REQ-026 trig_count_o increments on each synchronized trigger rising edge regardless of FSM state, wraps 2^TRIG_W-1 -> 0.
REQ-027 irq_o set when (meas_valid_o or timeout_o) and irq_en_i; cleared by clear_i; simultaneous set and clear: set wins.
REQ-028 clear_i with simultaneous trigger edge: trig_count_o <= 1.
REQ-029 Rising and falling edge in consecutive synchronized cycles SHALL both be honoured (minimum high time 1 cycle).

Reset
REQ-030 On rst: FSM IDLE; period_o, high_o, trig_count_o, counters = 0; meas_valid_o, timeout_o, irq_o, busy_o = 0; synchronizer flops = 0.
REQ-031 Reset de-assertion SHALL not create a spurious edge when pwm_i is already high (edge detector seeded from synchronizer output, first rising edge requires an observed low).

Structure
REQ-032 Shared package pwm_monitor_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-033 Sub-module sync_edge_det (2-flop synchronizer + rise/fall pulses) SHALL be instantiated twice, once per asynchronous input.

Verification
REQ-034 pwm_i 25 cycles high / 75 low, repeated, enable_i=1 -> meas_valid_o pulses every 100 cycles, period_o=100, high_o=25, starting from second rising edge.
REQ-035 pwm_i held low, TIMEOUT_CYC=500 -> timeout_o pulse 500 cycles after entering WAIT_RISE, irq_o=1 if irq_en_i=1, period_o unchanged.
REQ-036 pwm_i already high at reset release -> no meas_valid_o before a full low->high->low->high sequence.
REQ-037 10 trigger_i pulses, then clear_i coincident with 11th edge -> trig_count_o reaches 10, then 1.
REQ-038 enable_i dropped mid MEAS_LOW -> busy_o=0 next cycle, no meas_valid_o; re-enable with 40/60 PWM -> period_o=100, high_o=40.
REQ-039 pwm_i 1 cycle high / 2 low -> period_o=3, high_o=1, no missed edges.
